// File: rtl/prog_mem_loader.sv
// Program memory loader: streams a byte image into a 16x8 RAM,
// holds the CPU in reset while loading, then hands the RAM to the CPU.
module prog_mem_loader #(
    parameter int unsigned RELEASE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load_start,
    input  logic       load_valid,
    input  logic [7:0] load_data,
    input  logic       load_last,
    output logic       load_ready,
    input  logic [3:0] cpu_mem_address,
    input  logic [7:0] cpu_mem_data_w,
    input  logic       cpu_mem_we,
    output logic [7:0] cpu_mem_data_r,
    output logic       cpu_reset_n,
    output logic       load_busy,
    output logic       load_done,
    output logic [4:0] load_count
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RELEASE,
        RUN
    } state_t;

    localparam logic [3:0] REL_LAST = 4'(RELEASE_CYCLES);

    state_t     state;
    logic [7:0] mem [16];
    logic [3:0] ptr;
    logic [3:0] rel_cnt;
    logic       accept;
    logic       load_end;

    assign accept         = (state == LOAD) && load_ready && load_valid;
    assign load_end       = accept && (load_last || (ptr == 4'd15));
    assign cpu_mem_data_r = mem[cpu_mem_address];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            ptr         <= '0;
            rel_cnt     <= '0;
            load_count  <= '0;
            load_ready  <= 1'b0;
            load_busy   <= 1'b0;
            load_done   <= 1'b0;
            cpu_reset_n <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                mem[i] <= '0;
            end
        end else begin
            load_done <= 1'b0;
            unique case (state)
                IDLE, RUN: begin
                    // A restart beats a coincident CPU write.
                    if (load_start) begin
                        state       <= LOAD;
                        ptr         <= '0;
                        load_count  <= '0;
                        load_ready  <= 1'b1;
                        load_busy   <= 1'b1;
                        cpu_reset_n <= 1'b0;
                        for (int i = 0; i < 16; i++) begin
                            mem[i] <= '0;
                        end
                    end else if (state == RUN && cpu_mem_we) begin
                        mem[cpu_mem_address] <= cpu_mem_data_w;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        mem[ptr]   <= load_data;
                        load_count <= load_count + 5'd1;
                        if (load_end) begin
                            state      <= RELEASE;
                            load_ready <= 1'b0;
                            rel_cnt    <= '0;
                        end else begin
                            ptr <= ptr + 4'd1;
                        end
                    end
                end
                RELEASE: begin
                    if (rel_cnt == REL_LAST) begin
                        state       <= RUN;
                        cpu_reset_n <= 1'b1;
                        load_busy   <= 1'b0;
                        load_done   <= 1'b1;
                    end else begin
                        rel_cnt <= rel_cnt + 4'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_mem_loader.sv
// Bench for prog_mem_loader: fixed vector table, directed load
// sequences and random traffic against a behavioural model.
module tb_prog_mem_loader;

    localparam int R = 2;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       load_start;
    logic       load_valid;
    logic [7:0] load_data;
    logic       load_last;
    logic       load_ready;
    logic [3:0] cpu_mem_address;
    logic [7:0] cpu_mem_data_w;
    logic       cpu_mem_we;
    logic [7:0] cpu_mem_data_r;
    logic       cpu_reset_n;
    logic       load_busy;
    logic       load_done;
    logic [4:0] load_count;

    int n_vec = 0;
    int n_err = 0;

    prog_mem_loader #(.RELEASE_CYCLES(R)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .load_start      (load_start),
        .load_valid      (load_valid),
        .load_data       (load_data),
        .load_last       (load_last),
        .load_ready      (load_ready),
        .cpu_mem_address (cpu_mem_address),
        .cpu_mem_data_w  (cpu_mem_data_w),
        .cpu_mem_we      (cpu_mem_we),
        .cpu_mem_data_r  (cpu_mem_data_r),
        .cpu_reset_n     (cpu_reset_n),
        .load_busy       (load_busy),
        .load_done       (load_done),
        .load_count      (load_count)
    );

    always #50 clk = ~clk;

    // Behavioural model: image bytes, count, and where we are in the flow.
    logic [7:0] m_mem [16];
    int         m_cnt;
    bit         m_loading;
    int         m_rel;
    bit         m_running;
    bit         m_ready;
    bit         m_rst_n;
    bit         m_busy;
    bit         m_done;

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
        m_cnt     = 0;
        m_loading = 1'b0;
        m_rel     = -1;
        m_running = 1'b0;
        m_ready   = 1'b0;
        m_rst_n   = 1'b0;
        m_busy    = 1'b0;
        m_done    = 1'b0;
    endfunction

    function automatic void model_edge();
        m_done = 1'b0;
        if (load_start && !m_loading && m_rel < 0) begin
            for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
            m_cnt     = 0;
            m_loading = 1'b1;
            m_running = 1'b0;
            m_ready   = 1'b1;
            m_rst_n   = 1'b0;
            m_busy    = 1'b1;
        end else if (m_loading) begin
            if (load_valid) begin
                m_mem[m_cnt] = load_data;
                m_cnt++;
                if (load_last || m_cnt == 16) begin
                    m_loading = 1'b0;
                    m_ready   = 1'b0;
                    m_rel     = 0;
                end
            end
        end else if (m_rel >= 0) begin
            m_rel++;
            if (m_rel == R + 1) begin
                m_rel     = -1;
                m_running = 1'b1;
                m_rst_n   = 1'b1;
                m_busy    = 1'b0;
                m_done    = 1'b1;
            end
        end else if (m_running && cpu_mem_we) begin
            m_mem[cpu_mem_address] = cpu_mem_data_w;
        end
    endfunction

    task automatic check_model(input string tag);
        n_vec++;
        if (load_ready !== m_ready || cpu_reset_n !== m_rst_n ||
            load_busy !== m_busy || load_done !== m_done ||
            load_count !== 5'(m_cnt) ||
            cpu_mem_data_r !== m_mem[cpu_mem_address]) begin
            n_err++;
            $display("FAIL %s: got rdy=%b rst_n=%b busy=%b done=%b cnt=%0d rd=%h want %b %b %b %b %0d %h",
                     tag, load_ready, cpu_reset_n, load_busy, load_done,
                     load_count, cpu_mem_data_r, m_ready, m_rst_n, m_busy,
                     m_done, m_cnt, m_mem[cpu_mem_address]);
        end
    endtask

    task automatic check_val(input string tag, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", tag, act, exp);
        end
    endtask

    task automatic idle_inputs();
        load_start = 1'b0;
        load_valid = 1'b0;
        load_data  = 8'h00;
        load_last  = 1'b0;
        cpu_mem_we = 1'b0;
    endtask

    task automatic check_mem(input string tag);
        idle_inputs();
        for (int i = 0; i < 16; i++) begin
            cpu_mem_address = 4'(i);
            #2;
            n_vec++;
            if (cpu_mem_data_r !== m_mem[i]) begin
                n_err++;
                $display("FAIL %s: mem[%0d] got %h want %h",
                         tag, i, cpu_mem_data_r, m_mem[i]);
            end
        end
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    // Called just after a rising edge; returns before the next one.
    task automatic do_reset(input string tag);
        reset_n = 1'b0;
        model_reset();
        #2;
        check_model(tag);
        check_mem(tag);
        #5;
        reset_n = 1'b1;
    endtask

    task automatic send(input logic [7:0] d, input logic last);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        step("send");
    endtask

    typedef struct {
        logic       st;
        logic       vl;
        logic [7:0] d;
        logic       lst;
        logic [3:0] a;
        logic [7:0] wd;
        logic       we;
        logic       e_rdy;
        logic       e_rst;
        logic       e_busy;
        logic       e_done;
        logic [4:0] e_cnt;
        logic [7:0] e_rd;
    } vec_t;

    vec_t tbl [13];

    initial begin
        int k_hit;
        int dones;

        tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 8'h00};
        tbl[1]  = '{1'b0, 1'b1, 8'h83, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd1, 8'h83};
        tbl[2]  = '{1'b0, 1'b0, 8'h55, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd1, 8'h83};
        tbl[3]  = '{1'b0, 1'b1, 8'h91, 1'b0, 4'h1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd2, 8'h91};
        tbl[4]  = '{1'b0, 1'b0, 8'h22, 1'b1, 4'h3, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd2, 8'h00};
        tbl[5]  = '{1'b0, 1'b1, 8'h40, 1'b1, 4'h2, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd3, 8'h40};
        tbl[6]  = '{1'b0, 1'b0, 8'h00, 1'b0, 4'hE, 8'h05, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd3, 8'h00};
        tbl[7]  = '{1'b0, 1'b0, 8'h00, 1'b0, 4'h3, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd3, 8'h00};
        tbl[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 4'hE, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd3, 8'h00};
        tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 4'hE, 8'h05, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd3, 8'h05};
        tbl[10] = '{1'b0, 1'b1, 8'h77, 1'b0, 4'h3, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd3, 8'h00};
        tbl[11] = '{1'b1, 1'b0, 8'h00, 1'b0, 4'hE, 8'h09, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 8'h00};
        tbl[12] = '{1'b0, 1'b0, 8'h00, 1'b0, 4'hE, 8'h05, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 8'h00};

        reset_n         = 1'b0;
        cpu_mem_address = 4'h0;
        cpu_mem_data_w  = 8'h00;
        idle_inputs();
        model_reset();
        #10;
        check_model("por");
        #110;
        reset_n = 1'b1;
        step("idle");

        for (int i = 0; i < 13; i++) begin
            load_start      = tbl[i].st;
            load_valid      = tbl[i].vl;
            load_data       = tbl[i].d;
            load_last       = tbl[i].lst;
            cpu_mem_address = tbl[i].a;
            cpu_mem_data_w  = tbl[i].wd;
            cpu_mem_we      = tbl[i].we;
            model_edge();
            @(posedge clk);
            #1;
            n_vec++;
            if (load_ready !== tbl[i].e_rdy || cpu_reset_n !== tbl[i].e_rst ||
                load_busy !== tbl[i].e_busy || load_done !== tbl[i].e_done ||
                load_count !== tbl[i].e_cnt || cpu_mem_data_r !== tbl[i].e_rd) begin
                n_err++;
                $display("FAIL table[%0d]: got rdy=%b rst_n=%b busy=%b done=%b cnt=%0d rd=%h want %b %b %b %b %0d %h",
                         i, load_ready, cpu_reset_n, load_busy, load_done,
                         load_count, cpu_mem_data_r, tbl[i].e_rdy, tbl[i].e_rst,
                         tbl[i].e_busy, tbl[i].e_done, tbl[i].e_cnt, tbl[i].e_rd);
            end
            if (i == 8) check_mem("short_load_mem");
        end

        do_reset("reset_after_table");
        step("idle2");

        // Full 16-byte image, then a 17th byte offered during release.
        load_start = 1'b1;
        step("full_start");
        load_start = 1'b0;
        for (int i = 0; i < 16; i++) send(8'(8'h80 + i), 1'b0);
        check_val("full_count", int'(load_count), 16);
        load_data = 8'h90;
        k_hit = -1;
        dones = 0;
        for (int k = 1; k <= 8; k++) begin
            step("full_release");
            check_val("overrun_ready", int'(load_ready), 0);
            if (load_done) dones++;
            if (cpu_reset_n && k_hit < 0) k_hit = k;
        end
        check_val("release_edges", k_hit, R + 1);
        check_val("done_pulses", dones, 1);
        check_val("full_count_hold", int'(load_count), 16);
        check_mem("full_mem");

        // Reload while running.
        load_start = 1'b1;
        step("reload_start");
        check_val("reload_cpu_rst", int'(cpu_reset_n), 0);
        load_start = 1'b0;
        check_mem("reload_cleared");
        send(8'h11, 1'b0);
        send(8'h22, 1'b1);
        idle_inputs();
        dones = 0;
        for (int k = 0; k < 6; k++) begin
            step("reload_wait");
            if (load_done) dones++;
        end
        check_val("reload_done", dones, 1);
        check_mem("reload_mem");

        // Reset after five accepted bytes.
        load_start = 1'b1;
        step("midload_start");
        load_start = 1'b0;
        for (int i = 0; i < 5; i++) send(8'(8'hA0 + i), 1'b0);
        do_reset("midload_reset");
        step("after_reset");

        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(399) == 0) do_reset("rand_reset");
            load_start      = ($urandom_range(24) == 0);
            load_valid      = 1'($urandom_range(1));
            load_data       = 8'($urandom);
            load_last       = ($urandom_range(7) == 0);
            cpu_mem_address = 4'($urandom);
            cpu_mem_data_w  = 8'($urandom);
            cpu_mem_we      = ($urandom_range(2) == 0);
            step("random");
            if (i % 97 == 0) check_mem("random_mem");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
